frame_ram_arbiter: RTL
======================

# frame_ram_arbiter

Shares the single-port 24-bit frame RAM between two requesters: the display read path, which fetches pixels for the LED panel, and a frame write path, used by the pattern generator or loader. Each cycle it grants at most one access, drives the RAM control signals from registers, and returns read data with a valid strobe aligned to the RAM's pipeline latency. It sits between `frame_ram` and its clients at the display top level.

## Interface
- `ADDR_W`, 16, RAM address width.
- `DATA_W`, 24, pixel word width (8 bits each for R, G, B).
- `DEPTH`, 2048, valid words (`NUM_ROWS*NUM_COLS` = 32*64).
- `READ_LATENCY`, 1, RAM cycles from registered address to valid `ram_dout_in`. Legal values are 1 and 2.
- `MAX_RD_RUN`, 8, consecutive read grants allowed while a write waits. Used only when the guard macro is defined.

Ports:
- `clk_in`  in  1  system clock, 100 MHz.
- `n_reset_in`  in  1  asynchronous, active-low reset.
- `rd_req_in`  in  1  read request.
- `rd_addr_in`  in  ADDR_W  read address.
- `rd_ack_out`  out  1  read accepted this cycle.
- `rd_valid_out`  out  1  `rd_data_out` is valid.
- `rd_data_out`  out  DATA_W  read data.
- `wr_req_in`  in  1  write request.
- `wr_addr_in`  in  ADDR_W  write address.
- `wr_data_in`  in  DATA_W  write data.
- `wr_ack_out`  out  1  write accepted this cycle.
- `ram_en_out`  out  1  RAM enable.
- `ram_we_out`  out  1  RAM write enable.
- `ram_addr_out`  out  ADDR_W  RAM address.
- `ram_din_out`  out  DATA_W  RAM write data.
- `ram_dout_in`  in  DATA_W  RAM read data.
- `addr_err_out`  out  1  sticky out-of-range flag.

## Operation
- **Request handshake**
  - A requester holds `req` and its address/data stable until it sees `ack`.
  - The transfer occurs in the cycle where `req` and `ack` are both high.
  - `ack` is combinational from `req` and the arbiter state.
  - Back-to-back transfers are allowed: one grant per cycle in total.
- **Arbitration**
  - Fixed priority: read wins over write. The display must never stall.
  - At most one of `rd_ack_out` and `wr_ack_out` is high in any cycle.
- **RAM drive**
  - On a granted, in-range access, the next edge registers `ram_en_out=1`, the address, and `ram_we_out` (1 for a write), plus `ram_din_out` for a write.
  - Otherwise `ram_en_out=0` and `ram_we_out=0`. Address and data hold their last values.
- **Read return**
  - A valid shift register of depth `READ_LATENCY+1` tracks accepted reads.
  - `rd_data_out` is registered from `ram_dout_in` in the cycle the valid bit exits.
  - Reads return strictly in order.
- **Out of range (address ≥ `DEPTH`)**
  - The request is still acked, and the RAM is not enabled.
  - A read still produces `rd_valid_out` at the normal latency, with `rd_data_out=0`.
  - A write is dropped.
  - `addr_err_out` sets and stays set until reset.
- **Hazards**
  - A read accepted in the cycle after a write to the same address returns the new data. The RAM commits the write before the read's address edge.
- **Reset**
  - Asynchronous, at any time.
  - Clears all outputs and the valid pipeline. In-flight reads are discarded and produce no `rd_valid_out`.
  - Clears the run counter.

## Timing
- Reset values: every output is 0, including the RAM bus and `addr_err_out`.
- Read latency: read ack in cycle N gives `rd_valid_out` in cycle N+1+`READ_LATENCY` (N+2 at default).
- Write: ack in cycle N gives `ram_we_out` high in cycle N+1.
- Throughput: one access per cycle, sustained.
- A write request waiting under continuous reads starves indefinitely unless the guard macro is defined.

## Configuration
- Macro: `FRAME_RAM_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A counter (width `$clog2(MAX_RD_RUN+1)`) counts consecutive read grants while `wr_req_in` is high.
  - When it equals `MAX_RD_RUN`, the next cycle grants the write, `rd_ack_out` is 0, and the counter clears.
  - The counter also clears on any write grant or any cycle with `wr_req_in` low.
  - The guarantee is one write every `MAX_RD_RUN+1` cycles.
- **Undefined:** strict read priority. The counter is not built.

## Test plan
- **Reset:** assert `n_reset_in` mid-stream with 2 reads in flight -> all outputs 0 immediately; no `rd_valid_out` after release.
- **Write then read:** write 0xFF0000 to address 5 (ack N), read address 5 in cycle N+1 -> `rd_valid_out` at N+3 with data 0xFF0000.
- **Streaming:** `rd_req_in` high for 64 cycles, addresses 0..63 preloaded with value = address -> 64 consecutive valids, data 0..63 in order, no gaps.
- **Collision:** `rd_req_in` and `wr_req_in` rise in the same cycle -> read acked first; write acked the first cycle `rd_req_in` is low.
- **Starvation guard:** guard defined, `MAX_RD_RUN`=8, continuous reads plus a pending write -> write acked on the 9th cycle; `rd_ack_out`=0 in that cycle; reads resume. Without the macro -> write never acked.
- **Out of range:** read address 2048 -> acked, `ram_en_out` stays 0, valid with data 0 at N+2, `addr_err_out`=1 until reset.

Source files
------------

// File: rtl/frame_ram_arbiter.sv
// Arbiter sharing the single-port frame RAM between the display read path and the frame write path.
// Optional write starvation guard: define FRAME_RAM_ARB_STARVE_GUARD_EN.
module frame_ram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 24,
    parameter int DEPTH        = 2048,
    parameter int READ_LATENCY = 1,
    parameter int MAX_RD_RUN   = 8
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              rd_req_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_ack_out,
    output logic              rd_valid_out,
    output logic [DATA_W-1:0] rd_data_out,
    input  logic              wr_req_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ack_out,
    output logic              ram_en_out,
    output logic              ram_we_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_din_out,
    input  logic [DATA_W-1:0] ram_dout_in,
    output logic              addr_err_out
);

    localparam int PIPE_D = READ_LATENCY + 1;
    localparam logic [ADDR_W:0] DEPTH_X = DEPTH[ADDR_W:0];

    logic              rd_ack;
    logic              wr_ack;
    logic              force_wr;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [PIPE_D-1:0] vld_pipe;
    logic [PIPE_D-2:0] oor_pipe;

`ifdef FRAME_RAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_RD_RUN + 1);

    logic [CNT_W-1:0] rd_run;

    // Counts read grants that overtook a waiting write; at the limit the write is forced through.
    assign force_wr = wr_req_in && (rd_run == CNT_W'(MAX_RD_RUN));

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            rd_run <= '0;
        end else if (!wr_req_in || wr_ack) begin
            rd_run <= '0;
        end else if (rd_ack) begin
            rd_run <= rd_run + CNT_W'(1);
        end
    end
`else
    assign force_wr = (MAX_RD_RUN < 0);
`endif

    assign rd_in_range = ({1'b0, rd_addr_in} < DEPTH_X);
    assign wr_in_range = ({1'b0, wr_addr_in} < DEPTH_X);

    // Acks are masked during reset so every output reads 0 while reset is held.
    assign rd_ack = n_reset_in && rd_req_in && !force_wr;
    assign wr_ack = n_reset_in && wr_req_in && (!rd_req_in || force_wr);

    assign rd_ack_out   = rd_ack;
    assign wr_ack_out   = wr_ack;
    assign rd_valid_out = vld_pipe[PIPE_D-1];

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            ram_en_out   <= 1'b0;
            ram_we_out   <= 1'b0;
            ram_addr_out <= '0;
            ram_din_out  <= '0;
            addr_err_out <= 1'b0;
        end else begin
            ram_en_out <= 1'b0;
            ram_we_out <= 1'b0;
            if (rd_ack) begin
                if (rd_in_range) begin
                    ram_en_out   <= 1'b1;
                    ram_addr_out <= rd_addr_in;
                end else begin
                    addr_err_out <= 1'b1;
                end
            end else if (wr_ack) begin
                if (wr_in_range) begin
                    ram_en_out   <= 1'b1;
                    ram_we_out   <= 1'b1;
                    ram_addr_out <= wr_addr_in;
                    ram_din_out  <= wr_data_in;
                end else begin
                    addr_err_out <= 1'b1;
                end
            end
        end
    end

    // Out-of-range reads travel alongside the valid bit so they return zero at the normal latency.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            vld_pipe    <= '0;
            oor_pipe    <= '0;
            rd_data_out <= '0;
        end else begin
            vld_pipe[0] <= rd_ack;
            for (int i = 1; i < PIPE_D; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            oor_pipe[0] <= rd_ack && !rd_in_range;
            for (int i = 1; i < PIPE_D - 1; i++) begin
                oor_pipe[i] <= oor_pipe[i-1];
            end
            if (vld_pipe[PIPE_D-2]) begin
                rd_data_out <= oor_pipe[PIPE_D-2] ? '0 : ram_dout_in;
            end
        end
    end

endmodule
